// File: rtl/ptr_status.sv
// FIFO pointer status: synchronizes the remote Gray pointer and derives full/empty, almost and level.
// Optional almost-threshold logic enabled by macro PTR_STATUS_ALMOST_EN.
module ptr_status #(
    parameter int PtrWidth     = 2,
    parameter int NSync        = 2,
    parameter int IsWriteSide  = 0,
    parameter int AlmostThresh = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PtrWidth:0] i_local_bin_ptr_comb,
    input  logic [PtrWidth:0] i_remote_gray_ptr,
    output logic              o_flag,
    output logic              o_almost,
    output logic [PtrWidth:0] o_level,
    output logic [PtrWidth:0] o_remote_bin_ptr
);

    localparam int Depth = 2 ** PtrWidth;
    localparam logic RstFlag = (IsWriteSide != 0) ? 1'b0 : 1'b1;
    localparam logic [PtrWidth:0] MsbMask = (PtrWidth + 1)'(3 << (PtrWidth - 1));

    if (NSync < 2 || NSync > 4) begin : g_bad_nsync
        $error("ptr_status: NSync out of range");
    end
    if (AlmostThresh < 0 || AlmostThresh > Depth) begin : g_bad_thresh
        $error("ptr_status: AlmostThresh out of range");
    end
    if (PtrWidth < 1) begin : g_bad_width
        $error("ptr_status: PtrWidth must be at least 1");
    end

    logic [1:0]        rst_sync;
    logic              run;
    logic [PtrWidth:0] sync_q [NSync];
    logic [PtrWidth:0] remote_gray;
    logic [PtrWidth:0] remote_bin;
    logic [PtrWidth:0] local_gray;
    logic              flag_next;
    logic              almost_next;
    logic [PtrWidth:0] level_next;

    // Reset release is retimed so outputs leave reset on a clean edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Remote pointer crosses domains through this chain only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSync; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_remote_gray_ptr;
            for (int i = 1; i < NSync; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign remote_gray = sync_q[NSync-1];
    assign local_gray  = (i_local_bin_ptr_comb >> 1) ^ i_local_bin_ptr_comb;

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        remote_bin = '0;
        for (int i = 0; i <= PtrWidth; i++) begin
            remote_bin[i] = ^(remote_gray >> i);
        end
    end

    // Next-state flag, level and almost from one synchronized sample.
    always_comb begin
        flag_next  = 1'b0;
        level_next = '0;
        if (IsWriteSide != 0) begin
            flag_next  = (local_gray == (remote_gray ^ MsbMask));
            level_next = i_local_bin_ptr_comb - remote_bin;
        end else begin
            flag_next  = (local_gray == remote_gray);
            level_next = remote_bin - i_local_bin_ptr_comb;
        end
    end

`ifdef PTR_STATUS_ALMOST_EN
    localparam logic [PtrWidth:0] WrThr = (PtrWidth + 1)'(Depth - AlmostThresh);
    localparam logic [PtrWidth:0] RdThr = (PtrWidth + 1)'(AlmostThresh);

    // Almost threshold compare on the next level.
    always_comb begin
        almost_next = RstFlag;
        if (IsWriteSide != 0) begin
            almost_next = (level_next >= WrThr);
        end else begin
            almost_next = (level_next <= RdThr);
        end
    end
`else
    assign almost_next = RstFlag;
`endif

    // Output registers, held at reset values until reset release settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_flag           <= RstFlag;
            o_almost         <= RstFlag;
            o_level          <= '0;
            o_remote_bin_ptr <= '0;
        end else if (!run) begin
            o_flag           <= RstFlag;
            o_almost         <= RstFlag;
            o_level          <= '0;
            o_remote_bin_ptr <= '0;
        end else begin
            o_flag           <= flag_next;
            o_almost         <= almost_next;
            o_level          <= level_next;
            o_remote_bin_ptr <= remote_bin;
        end
    end

endmodule

// File: tb/tb_ptr_status.sv
// Directed bench for ptr_status: one write-side and one read-side instance.
module tb_ptr_status;

`ifdef PTR_STATUS_ALMOST_EN
    localparam bit ALM = 1'b1;
`else
    localparam bit ALM = 1'b0;
`endif

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [2:0] wl, wr, rl, rr;
    logic       w_flag, w_almost, r_flag, r_almost;
    logic [2:0] w_level, w_rbin, r_level, r_rbin;
    int         vecs;
    int         errs;

    ptr_status #(.PtrWidth(2), .NSync(2), .IsWriteSide(1), .AlmostThresh(1)) u_w (
        .clk(clk),
        .rst_n(rst_n),
        .i_local_bin_ptr_comb(wl),
        .i_remote_gray_ptr(wr),
        .o_flag(w_flag),
        .o_almost(w_almost),
        .o_level(w_level),
        .o_remote_bin_ptr(w_rbin)
    );

    ptr_status #(.PtrWidth(2), .NSync(2), .IsWriteSide(0), .AlmostThresh(1)) u_r (
        .clk(clk),
        .rst_n(rst_n),
        .i_local_bin_ptr_comb(rl),
        .i_remote_gray_ptr(rr),
        .o_flag(r_flag),
        .o_almost(r_almost),
        .o_level(r_level),
        .o_remote_bin_ptr(r_rbin)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        clk_en = 1'b1;
        rst_n = 1'b1;
        wl = 3'd0; wr = 3'd0; rl = 3'd0; rr = 3'd0;
        #1 rst_n = 1'b0;
        wl = 3'd2;
        #1;
        chk("rst_w_flag", w_flag, 0);
        chk("rst_w_alm", w_almost, 0);
        chk("rst_w_lvl", w_level, 0);
        chk("rst_w_rbin", w_rbin, 0);
        chk("rst_r_flag", r_flag, 1);
        chk("rst_r_alm", r_almost, 1);
        chk("rst_r_lvl", r_level, 0);
        chk("rst_r_rbin", r_rbin, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_hold1", w_level, 0);
        tick();
        chk("rel_hold2", w_level, 0);
        tick();
        chk("rel_w_lvl", w_level, 2);
        chk("rel_w_flag", w_flag, 0);
        chk("rel_r_flag", r_flag, 1);
        chk("rel_r_lvl", r_level, 0);
        chk("rel_r_alm", r_almost, 1);

        wl = 3'd1; tick();
        chk("fill_l1", w_level, 1);
        wl = 3'd2; tick();
        chk("fill_l2", w_level, 2);
        wl = 3'd3; tick();
        chk("fill_l3", w_level, 3);
        chk("fill_f3", w_flag, 0);
        chk("fill_a3", w_almost, ALM ? 1 : 0);
        wl = 3'd4; tick();
        chk("fill_l4", w_level, 4);
        chk("fill_f4", w_flag, 1);
        chk("fill_a4", w_almost, ALM ? 1 : 0);
        chk("fill_rbin", w_rbin, 0);

        wr = 3'b110;
        tick();
        chk("wlat_l1", w_level, 4);
        tick();
        chk("wlat_l2", w_level, 4);
        chk("wlat_f2", w_flag, 1);
        tick();
        chk("wlat_l3", w_level, 0);
        chk("wlat_f3", w_flag, 0);
        chk("wlat_rbin", w_rbin, 4);
        chk("wlat_a3", w_almost, 0);
        wl = 3'd7; tick();
        chk("wrap_l7", w_level, 3);
        chk("wrap_f7", w_flag, 0);
        chk("wrap_a7", w_almost, ALM ? 1 : 0);
        wl = 3'd0; tick();
        chk("wrap_l0", w_level, 4);
        chk("wrap_f0", w_flag, 1);

        rr = 3'b001;
        tick();
        chk("rlat_f1", r_flag, 1);
        chk("rlat_l1", r_level, 0);
        tick();
        chk("rlat_f2", r_flag, 1);
        tick();
        chk("rlat_f3", r_flag, 0);
        chk("rlat_l3", r_level, 1);
        chk("rlat_rbin", r_rbin, 1);
        chk("rlat_a3", r_almost, 1);

        rl = 3'd1;
        rr = 3'b011;
        tick();
        chk("simul_f1", r_flag, 1);
        chk("simul_l1", r_level, 0);
        tick();
        chk("simul_f2", r_flag, 1);
        tick();
        chk("simul_f3", r_flag, 0);
        chk("simul_l3", r_level, 1);
        chk("simul_rbin", r_rbin, 2);

        rr = 3'b010;
        tick(); tick(); tick();
        chk("rd_l2", r_level, 2);
        chk("rd_a2", r_almost, ALM ? 0 : 1);
        chk("rd_rbin3", r_rbin, 3);

        wl = 3'd7; tick();
        chk("mid_w_l3", w_level, 3);
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("arst_w_flag", w_flag, 0);
        chk("arst_w_alm", w_almost, 0);
        chk("arst_w_lvl", w_level, 0);
        chk("arst_w_rbin", w_rbin, 0);
        chk("arst_r_flag", r_flag, 1);
        chk("arst_r_alm", r_almost, 1);
        chk("arst_r_lvl", r_level, 0);
        chk("arst_r_rbin", r_rbin, 0);
        #5 rst_n = 1'b1;
        #1 clk_en = 1'b1;
        tick();
        chk("arel_h1", w_level, 0);
        tick();
        chk("arel_h2", w_level, 0);
        chk("arel_h2_r", r_flag, 1);
        tick();
        chk("arel_w_lvl", w_level, 3);
        chk("arel_w_rbin", w_rbin, 4);
        chk("arel_w_flag", w_flag, 0);
        chk("arel_r_lvl", r_level, 2);
        chk("arel_r_flag", r_flag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
